// File: rtl/risc_pkg.sv
// Shared types for the data-memory responder: word width, FSM state encoding
// and the latched request record.
package risc_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x WORD_W, write-enable and registered read.
// Contents are deliberately not reset.
module dmem_array
    import risc_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data-memory responder: IDLE -> [WAIT] -> RESP.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES wait states per access.
module data_mem_responder
    import risc_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmem_state_e       state_q, state_d;
    dmem_req_t         req_q, req_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rd_sel_q, rd_sel_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              enter_resp;
    logic              acc_ok;
    logic              mem_en;
    logic [WORD_W-1:0] mem_rdata;

`ifdef DMEM_WAIT_EN
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rd_sel_d    = rd_sel_q;
        enter_resp  = 1'b0;
        acc_ok      = 1'b0;
        mem_en      = 1'b0;
`ifdef DMEM_WAIT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = '{we: req_we, addr: req_addr, wdata: req_wdata};
`ifdef DMEM_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end else begin
                        enter_resp = 1'b1;
                    end
`else
                    enter_resp = 1'b1;
`endif
                end
            end
`ifdef DMEM_WAIT_EN
            WAIT: begin
                if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rd_sel_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // The single array access happens on the edge that enters RESP;
        // rst on that edge suppresses it so an abandoned write never lands.
        if (enter_resp) begin
            state_d     = RESP;
            acc_ok      = 32'(req_d.addr) < DEPTH;
            rsp_valid_d = 1'b1;
            rsp_err_d   = !acc_ok;
            rd_sel_d    = acc_ok && !req_d.we;
            mem_en      = acc_ok && !rst;
        end

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef DMEM_WAIT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_sel_q    <= rd_sel_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
`ifdef DMEM_WAIT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .we    (req_d.we),
        .addr  (req_d.addr[AW-1:0]),
        .wdata (req_d.wdata),
        .rdata (mem_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    // Read data is only exposed for in-range reads; writes and errors return 0.
    assign rsp_rdata = rd_sel_q ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against an array model.
module tb_data_mem_responder;

    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_EN
    localparam int LAT = 1 + WAIT_CYCLES;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    logic [15:0] mdl [int];
    logic [15:0] addrs [8];

    data_mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete access: present, accept, await response, optionally stall
    // rsp_ready for 'hold' cycles (with ignored request pulses), then handshake.
    task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input int hold, input bit pulse);
        logic [15:0] exp_d;
        logic        exp_e;
        logic [15:0] snap;
        int          n;
        exp_e = (addr >= 16'(DEPTH));
        exp_d = (we || exp_e) ? 16'h0000 : mdl[int'(addr)];
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        acc_cyc   = cyc;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 16'($urandom); req_wdata = 16'($urandom);
        if (we && !exp_e) mdl[int'(addr)] = wdata;
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, LAT);
        check("busy_resp", busy, 1);
        check("req_ready_resp", req_ready, 0);
        check("rdata", rsp_rdata, exp_d);
        check("err", rsp_err, exp_e);
        snap = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                req_valid = 1'b1; req_we = 1'b1;
                req_addr  = exp_e ? 16'h0010 : addr;
                req_wdata = 16'($urandom);
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, snap);
            check("hold_err", rsp_err, exp_e);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_valid", rsp_valid, 0);
        check("post_busy", busy, 0);
        $display("txn we=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d hold=%0d",
                 we, addr, wdata, snap, exp_e, n, hold);
    endtask

    initial begin
        logic [15:0] prior;
        int          prev_acc;
        addrs = '{16'h0000, 16'h0005, 16'h0010, 16'h00FF, 16'h0042, 16'h0080, 16'h00FE, 16'h0001};

        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_req_ready", req_ready, 1);

        // Write then read back a known word
        access(1'b1, 16'h0010, 16'hBEEF, 0, 1'b0);
        access(1'b0, 16'h0010, 16'h0000, 0, 1'b0);

        foreach (addrs[i]) access(1'b1, addrs[i], 16'($urandom), 0, 1'b0);

        // Out-of-range read, then the top in-range word
        access(1'b0, 16'h0100, 16'h0000, 0, 1'b0);
        access(1'b0, 16'h00FF, 16'h0000, 0, 1'b0);

        // Stalled response with ignored request pulses
        access(1'b0, 16'h0010, 16'h0000, 5, 1'b1);
        access(1'b1, 16'h0300, 16'h5555, 5, 1'b1);
        access(1'b0, 16'h0010, 16'h0000, 0, 1'b0);

        // Reset during an in-flight write must drop it
        prior = mdl[5];
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0005; req_wdata = 16'h1234;
`ifdef DMEM_WAIT_EN
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`else
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 1'b0;
`endif
        check("abort_busy_clr", busy, 0);
        check("abort_req_ready", req_ready, 1);
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", rsp_valid, 0);
        end
        check("abort_model_prior", mdl[5], prior);
        access(1'b0, 16'h0005, 16'h0000, 0, 1'b0);

        // Back-to-back writes then readback
        prev_acc = -1;
        for (int i = 0; i < 4; i++) begin
            access(1'b1, addrs[i+4], 16'($urandom), 0, 1'b0);
            if (prev_acc >= 0) check("b2b_gap", acc_cyc - prev_acc, LAT + 1);
            prev_acc = acc_cyc;
        end
        for (int i = 0; i < 4; i++) access(1'b0, addrs[i+4], 16'h0000, 0, 1'b0);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(DEPTH, 65535));
            else a = addrs[$urandom_range(0, 7)];
            access(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 16-bit words in the data array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per access (used only when DMEM_WAIT_EN is defined).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  CPU presents an access.
REQ-006 SHALL have port req_ready  output  1  responder accepts an access this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  16  word address.
REQ-009 SHALL have port req_wdata  input  16  write data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  CPU consumes the response.
REQ-012 SHALL have port rsp_rdata  output  16  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err  output  1  access was out of range.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 IDLE: req_ready=1; on req_valid&&req_ready SHALL latch we, addr and wdata, then go to WAIT (WAIT_CYCLES>0, macro defined) or RESP.
REQ-017 WAIT: req_ready=0; SHALL count WAIT_CYCLES cycles, then go to RESP.
REQ-018 Array access (write commit or read capture) SHALL occur exactly once, on the cycle of entry into RESP.
REQ-019 RESP: rsp_valid=1; rsp_rdata and rsp_err SHALL hold stable until rsp_valid&&rsp_ready, then go to IDLE.
REQ-020 Latency: accept at cycle N gives rsp_valid at N+1+WAIT_CYCLES (N+1 without macro).
REQ-021 Back-to-back: req_ready SHALL remain 0 in the cycle of the response handshake; the next accept SHALL occur no earlier than the following cycle.
REQ-022 Every write SHALL produce one response (acknowledge) with rsp_rdata=0.
REQ-023 Address is out of range when addr >= DEPTH: SHALL not modify the array, and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-024 req_valid while not in IDLE SHALL be ignored without side effects.
REQ-025 Read of an in-range address SHALL return the last value written there.

Reset
REQ-026 On rst: state=IDLE; wait counter=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0; req_ready=1 from the first cycle after rst deasserts.
REQ-027 rst mid-access SHALL abandon the access; an uncommitted write SHALL NOT reach the array, and no response SHALL be issued.
REQ-028 rst SHALL NOT clear the array contents.

Configuration
REQ-029 Macro DMEM_WAIT_EN defined: the WAIT state and counter SHALL be present and WAIT_CYCLES SHALL apply; WAIT_CYCLES=0 SHALL skip WAIT.
REQ-030 Macro DMEM_WAIT_EN undefined: WAIT and the counter SHALL be absent; the FSM SHALL go IDLE->RESP directly, and WAIT_CYCLES SHALL be ignored.

Structure
REQ-031 Package risc_pkg SHALL hold WORD_W=16, the state enum type (IDLE/WAIT/RESP) and the request struct (we, addr, wdata).
REQ-032 Storage SHALL be a sub-module dmem_array: single-port synchronous RAM, DEPTH x 16, write-enable, registered read.

Verification (DEPTH=256, WAIT_CYCLES=2, macro defined unless noted)
REQ-033 Write 0xBEEF to addr 0x0010, then read 0x0010 -> write ack with rsp_rdata=0 at N+3; read returns 0xBEEF with rsp_err=0.
REQ-034 Read addr 0x0100 -> rsp_err=1, rsp_rdata=0; a following read of 0x00FF is unchanged.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable; req_valid pulses meanwhile are ignored.
REQ-036 rst asserted in WAIT of a write of 0x1234 to addr 0x0005 -> no response; a later read of 0x0005 returns the prior value.
REQ-037 Macro undefined: read accepted at cycle N -> rsp_valid at N+1.
REQ-038 Four back-to-back writes with rsp_ready=1 -> each accepted every 4 cycles, four acks, and all four words read back correctly.
